// File: rtl/button_count_initiator.sv
// Caller side of the count_value method: synchronise and debounce a pushbutton, queue presses,
// and issue one EN_count_value call per queued press while RDY_count_value is high.
// Optional build macro AUTO_REPEAT_EN adds periodic repeat presses while the button is held.
module button_count_initiator #(
  parameter int CNT_W           = 4,
  parameter int PEND_W          = 3,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int REPEAT_CYCLES   = 6000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              btn,
  input  logic              RDY_count_value,
  input  logic [CNT_W-1:0]  count_value,
  output logic              EN_count_value,
  output logic [CNT_W-1:0]  leds,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("DEBOUNCE_CYCLES and REPEAT_CYCLES must both be at least 2");
  end

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    CHK_PRESS   = 2'd1,
    HELD        = 2'd2,
    CHK_RELEASE = 2'd3
  } deb_state_e;

  logic              sync1_d, sync1_q;
  logic              sync2_d, sync2_q;
  logic              btn_s;
  deb_state_e        state_d, state_q;
  logic [DCNT_W-1:0] dcnt_d, dcnt_q;
  logic              deb_press;
  logic              press;
  logic              call;
  logic [PEND_W-1:0] pending_d, pending_q;
  logic [CNT_W-1:0]  leds_d, leds_q;
  logic              overflow_d, overflow_q;

  // Two-flop synchroniser for the asynchronous pin.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s = sync2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RELEASED;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // A change is accepted only once btn_s has held the new level for the whole count window.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d = CHK_PRESS;
          dcnt_d  = '0;
        end
      end
      CHK_PRESS: begin
        if (!btn_s) begin
          state_d = RELEASED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = HELD;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = CHK_RELEASE;
          dcnt_d  = '0;
        end
      end
      CHK_RELEASE: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = RELEASED;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        dcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    deb_press = (state_q == CHK_PRESS) && btn_s && (dcnt_q == DCNT_LAST);
  end

`ifdef AUTO_REPEAT_EN
  localparam int RCNT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

  logic [RCNT_W-1:0] rcnt_d, rcnt_q;
  logic              rep_press;

  // The repeat counter only runs while HELD stays HELD, so any entry or exit restarts it at 0.
  always_comb begin
    rcnt_d    = '0;
    rep_press = 1'b0;
    if (state_q == HELD && btn_s) begin
      if (rcnt_q == RCNT_LAST) begin
        rep_press = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end

  assign press = deb_press | rep_press;
`else
  assign press = deb_press;
`endif

  assign call           = (pending_q != '0) && RDY_count_value;
  assign EN_count_value = call;

  // A press and a call in the same cycle cancel; a press with no room is dropped and flagged.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    leds_d     = call ? count_value : leds_q;
    if (press && !call) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (call && !press) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q  <= '0;
      leds_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      leds_q     <= leds_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign leds     = leds_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_button_count_initiator.sv
// Bench for button_count_initiator: directed button/RDY scenarios checked every cycle against
// a stability-window model of the button plus a saturating queue model of the caller.
module tb_button_count_initiator;

  localparam int CNT_W  = 4;
  localparam int PEND_W = 2;
  localparam int DEB    = 16;
  localparam int REP    = 40;
  localparam int PMAX   = 3;

  logic              CLK = 1'b0;
  logic              RST;
  logic              btn;
  logic              rdy;
  logic [CNT_W-1:0]  count_value;
  logic              en;
  logic [CNT_W-1:0]  leds;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  logic [CNT_W-1:0]  stub_base;
  logic [CNT_W-1:0]  stub_calls;

  int tests = 0;
  int fails = 0;
  int en_total = 0;
  bit model_on = 1'b0;

  // Model state: pin history, accepted level, run of disagreeing cycles, hold timer, queue.
  int m_s1, m_s2, m_deb, m_run, m_rcnt, m_pend, m_leds, m_ovf;

  button_count_initiator #(
    .CNT_W(CNT_W), .PEND_W(PEND_W), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .CLK(CLK), .RST(RST), .btn(btn), .RDY_count_value(rdy), .count_value(count_value),
    .EN_count_value(en), .leds(leds), .pending(pending), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Callee stub: returns stub_base + number of calls taken so far.
  assign count_value = stub_base + stub_calls;
  always @(posedge CLK or posedge RST) begin
    if (RST) stub_calls <= '0;
    else if (en) stub_calls <= stub_calls + 1'b1;
  end

  always @(negedge CLK) if (en === 1'b1) en_total++;

  // A level is accepted after DEB+1 consecutive synchronised samples differing from the old one.
  always @(posedge CLK or posedge RST) begin
    int press, call, held;
    if (RST) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0; m_rcnt = 0;
      m_pend = 0; m_leds = 0; m_ovf = 0;
    end else begin
      press = 0;
      held = (m_deb == 1 && m_run == 0);
      if (m_s2 != m_deb) begin
        m_rcnt = 0;
        m_run++;
        if (m_run == DEB + 1) begin
          m_deb = m_s2;
          m_run = 0;
          if (m_deb == 1) press = 1;
        end
      end else begin
`ifdef AUTO_REPEAT_EN
        if (held) begin
          m_rcnt++;
          if (m_rcnt == REP) begin
            press = 1;
            m_rcnt = 0;
          end
        end else begin
          m_rcnt = 0;
        end
`else
        m_rcnt = held ? 0 : 0;
`endif
        m_run = 0;
      end
      call = (m_pend != 0 && rdy) ? 1 : 0;
      if (call) m_leds = int'(count_value);
      if (press && !call) begin
        if (m_pend == PMAX) m_ovf = 1;
        else m_pend++;
      end else if (call && !press) begin
        m_pend--;
      end
      m_s2 = m_s1;
      m_s1 = int'(btn);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (model_on && RST === 1'b0) begin
      checkOutput("cyc_en", int'(en), (m_pend != 0 && rdy) ? 1 : 0);
      checkOutput("cyc_pending", int'(pending), m_pend);
      checkOutput("cyc_leds", int'(leds), m_leds);
      checkOutput("cyc_overflow", int'(overflow), m_ovf);
    end
  end

  // Drive pin and RDY, then let the given number of cycles pass (called at posedge+1).
  task automatic applyStimulus(input logic b, input logic r, input int cycles);
    btn = b;
    rdy = r;
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pressOnce(input logic r);
    applyStimulus(1'b1, r, 24);
    applyStimulus(1'b0, r, 24);
  endtask

  // Counts clock edges (sampling edge first) until EN is seen; -1 on timeout.
  task automatic waitEn(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (en === 1'b1) begin
        n = i;
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int e0, n;
    RST = 1'b1; btn = 1'b0; rdy = 1'b1; stub_base = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_pending", int'(pending), 0);
    checkOutput("reset_leds", int'(leds), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_en", int'(en), 0);
    @(negedge CLK);
    RST = 1'b0;
    model_on = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] scenario: bounce");
    applyStimulus(1'b0, 1'b1, 5);
    e0 = en_total;
    for (int i = 0; i < 20; i++) applyStimulus((i % 2) == 0, 1'b1, 5);
    btn = 1'b1;
    waitEn(n);
    checkOutput("press_latency", n - 1, DEB + 2);
    applyStimulus(1'b1, 1'b1, 5);
    for (int i = 0; i < 5; i++) applyStimulus((i % 2) == 1, 1'b1, 5);
    applyStimulus(1'b0, 1'b1, 30);
    checkOutput("bounce_pulses", en_total - e0, 1);
    checkOutput("bounce_pending", int'(pending), 0);

    $display("[TB] scenario: blocked");
    stub_base = 4'd7 - stub_calls;
    e0 = en_total;
    for (int i = 0; i < 3; i++) pressOnce(1'b0);
    checkOutput("blocked_pending", int'(pending), 3);
    checkOutput("blocked_no_en", en_total - e0, 0);
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("blocked_calls", en_total - e0, 3);
    checkOutput("blocked_leds", int'(leds), 9);
    checkOutput("blocked_drained", int'(pending), 0);

    $display("[TB] scenario: overflow");
    checkOutput("ovf_before", int'(overflow), 0);
    for (int i = 0; i < 4; i++) pressOnce(1'b0);
    checkOutput("ovf_pending", int'(pending), 3);
    checkOutput("ovf_flag", int'(overflow), 1);
    e0 = en_total;
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("ovf_calls", en_total - e0, 3);
    checkOutput("ovf_sticky", int'(overflow), 1);

    $display("[TB] scenario: collision");
    pressOnce(1'b0);
    checkOutput("coll_pending_start", int'(pending), 1);
    btn = 1'b1;
    repeat (DEB + 2) @(posedge CLK);
    #1;
    rdy = 1'b1;
    @(negedge CLK);
    checkOutput("coll_en", int'(en), 1);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("coll_pending_hold", int'(pending), 1);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("coll_pending_done", int'(pending), 0);
    @(posedge CLK);
    #1;
    applyStimulus(1'b0, 1'b1, 30);

    $display("[TB] scenario: reset mid-operation");
    for (int i = 0; i < 2; i++) pressOnce(1'b0);
    checkOutput("rst_pending_before", int'(pending), 2);
    #3;
    RST = 1'b1;
    #1;
    checkOutput("rst_pending", int'(pending), 0);
    checkOutput("rst_leds", int'(leds), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_en", int'(en), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    e0 = en_total;
    applyStimulus(1'b0, 1'b1, 30);
    checkOutput("rst_no_calls", en_total - e0, 0);

    $display("[TB] scenario: long hold");
    e0 = en_total;
    btn = 1'b1;
    rdy = 1'b1;
    waitEn(n);
    checkOutput("hold_latency", n - 1, DEB + 2);
    applyStimulus(1'b1, 1'b1, 100);
    applyStimulus(1'b0, 1'b1, 30);
`ifdef AUTO_REPEAT_EN
    checkOutput("hold_presses", en_total - e0, 3);
`else
    checkOutput("hold_presses", en_total - e0, 1);
`endif

    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
